// File: rtl/tstate_sequencer_pkg.sv
// Shared definitions for the T-state sequencer and the instruction decoder.
//   INT_OPC_DEFAULT : opcode forced into the instruction register for
//                     reset / NMI / IRQ sequences
//   kind_e          : which interrupt sequence (if any) is in progress
//   lowest_set()    : index of the lowest set bit of an IRQ vector
//                     (up to MAX_IRQ lines, 0 when none are set)
package tstate_sequencer_pkg;

  localparam logic [7:0] INT_OPC_DEFAULT = 8'h00;
  localparam int         MAX_IRQ         = 8;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_RST  = 2'd1,
    KIND_NMI  = 2'd2,
    KIND_IRQ  = 2'd3
  } kind_e;

  function automatic logic [2:0] lowest_set(input logic [MAX_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tstate_sequencer_int_arbiter.sv
// Interrupt arbiter for the T-state sequencer.
// Holds the reset-pending and NMI-pending latches plus the NMI edge detector,
// and combinationally picks the sequence to start at the next boundary:
// reset > NMI > unmasked IRQ (lowest line) > none.
// Ports:
//   clk, clr      : clock, async active-high reset
//   rdy           : memory ready; gates the sinst clear (edge detect runs freely)
//   sinst         : decoder accepted the current interrupt sequence
//   cur_kind      : kind of the sequence currently executing
//   irq, irq_dis  : level IRQ lines and global mask
//   nmi           : rising-edge NMI input
//   kind, idx     : arbitration result and IRQ line index
module int_arbiter
  import tstate_sequencer_pkg::*;
#(
  parameter int NUM_IRQ = 1,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               rdy,
  input  logic               sinst,
  input  kind_e              cur_kind,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_dis,
  input  logic               nmi,
  output kind_e              kind,
  output logic [IDX_W-1:0]   idx
);

  logic               rst_pend;
  logic               nmi_pend;
  logic               nmi_q;
  logic               nmi_edge;
  logic               nmi_clr;
  logic [NUM_IRQ-1:0] irq_act;
  logic [MAX_IRQ-1:0] irq_ext;

  assign nmi_edge = nmi & ~nmi_q;
  assign nmi_clr  = rdy & sinst & (cur_kind == KIND_NMI);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      nmi_q <= nmi;
      // A fresh edge in the same clock as the clear must not be lost.
      nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);
      if (rdy && sinst && (cur_kind == KIND_RST)) rst_pend <= 1'b0;
    end
  end

  assign irq_act = irq & ~{NUM_IRQ{irq_dis}};
  assign irq_ext = MAX_IRQ'(irq_act);

  always_comb begin
    kind = KIND_NONE;
    idx  = '0;
    if (rst_pend)        kind = KIND_RST;
    else if (nmi_pend)   kind = KIND_NMI;
    else if (|irq_act) begin
      kind = KIND_IRQ;
      idx  = IDX_W'(lowest_set(irq_ext));
    end
  end

endmodule

// File: rtl/tstate_sequencer.sv
// T-state sequencer: front end of the instruction decoder.
// Owns the instruction register, the T-state counter and the current
// interrupt kind; starts a new sequence on rcyc using int_arbiter's choice.
// Ports:
//   clk, clr               : clock, async active-high reset
//   rdy                    : memory ready, low freezes sequencing
//   dbus                   : opcode on fetch
//   icyc/rcyc/scyc/sinst   : decoder strobes (advance / boundary / hold / accept)
//   irq, irq_dis, nmi      : interrupt sources and mask
//   inst, cycle            : instruction register and T-state to the decoder
//   rst_o/nmi_o/irq_o      : one-hot kind of the current sequence
//   irq_idx                : IRQ line being serviced
//   seq_err                : sticky cycle counter overflow
//
// state (kind_q) | meaning
// KIND_RST       | reset sequence executing (initial after clr)
// KIND_NMI       | NMI sequence executing
// KIND_IRQ       | IRQ sequence executing, irq_idx valid
// KIND_NONE      | normal instruction fetched from dbus
module tstate_sequencer
  import tstate_sequencer_pkg::*;
#(
  parameter int               CYC_W   = 3,
  parameter int               OPC_W   = 8,
  parameter logic [OPC_W-1:0] INT_OPC = OPC_W'(INT_OPC_DEFAULT),
  parameter int               NUM_IRQ = 1,
  parameter int               IDX_W   = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               rdy,
  input  logic [OPC_W-1:0]   dbus,
  input  logic               icyc,
  input  logic               rcyc,
  input  logic               scyc,
  input  logic               sinst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_dis,
  input  logic               nmi,
  output logic [OPC_W-1:0]   inst,
  output logic [CYC_W-1:0]   cycle,
  output logic               rst_o,
  output logic               nmi_o,
  output logic               irq_o,
  output logic [IDX_W-1:0]   irq_idx,
  output logic               seq_err
);

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  kind_e            kind_q, kind_d, arb_kind;
  logic [OPC_W-1:0] inst_q, inst_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] idx_q, idx_d, arb_idx;
  logic             err_q, err_d;

  int_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk      (clk),
    .clr      (clr),
    .rdy      (rdy),
    .sinst    (sinst),
    .cur_kind (kind_q),
    .irq      (irq),
    .irq_dis  (irq_dis),
    .nmi      (nmi),
    .kind     (arb_kind),
    .idx      (arb_idx)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      kind_q <= KIND_RST;
      inst_q <= INT_OPC;
      cyc_q  <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      kind_q <= kind_d;
      inst_q <= inst_d;
      cyc_q  <= cyc_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    kind_d = kind_q;
    inst_d = inst_q;
    cyc_d  = cyc_q;
    idx_d  = idx_q;
    err_d  = err_q;
    if (rdy) begin
      if (rcyc) begin
        cyc_d  = '0;
        kind_d = arb_kind;
        idx_d  = (arb_kind == KIND_IRQ) ? arb_idx : '0;
        inst_d = (arb_kind == KIND_NONE) ? dbus : INT_OPC;
      end else if (scyc) begin
        cyc_d = cyc_q;
      end else if (icyc) begin
        // Overflow wraps the counter but keeps the instruction; flag is sticky.
        if (cyc_q == CYC_MAX) begin
          cyc_d = '0;
          err_d = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
    end
  end

  assign inst    = inst_q;
  assign cycle   = cyc_q;
  assign rst_o   = (kind_q == KIND_RST);
  assign nmi_o   = (kind_q == KIND_NMI);
  assign irq_o   = (kind_q == KIND_IRQ);
  assign irq_idx = idx_q;
  assign seq_err = err_q;

endmodule

// File: tb/tb_tstate_sequencer.sv
module tb_tstate_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       rdy;
  logic [7:0] dbus;
  logic       icyc, rcyc, scyc, sinst;
  logic [3:0] irq;
  logic       irq_dis;
  logic       nmi;
  logic [7:0] inst;
  logic [2:0] cycle;
  logic       rst_o, nmi_o, irq_o;
  logic [2:0] irq_idx;
  logic       seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] K0 = 3'b000;
  localparam logic [2:0] KR = 3'b100;
  localparam logic [2:0] KN = 3'b010;
  localparam logic [2:0] KI = 3'b001;

  tstate_sequencer #(
    .CYC_W   (3),
    .OPC_W   (8),
    .INT_OPC (8'h00),
    .NUM_IRQ (4),
    .IDX_W   (3)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .rdy     (rdy),
    .dbus    (dbus),
    .icyc    (icyc),
    .rcyc    (rcyc),
    .scyc    (scyc),
    .sinst   (sinst),
    .irq     (irq),
    .irq_dis (irq_dis),
    .nmi     (nmi),
    .inst    (inst),
    .cycle   (cycle),
    .rst_o   (rst_o),
    .nmi_o   (nmi_o),
    .irq_o   (irq_o),
    .irq_idx (irq_idx),
    .seq_err (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rcyc, icyc, scyc, sinst, nmi;
    logic [3:0] irq;
    logic       dis;
    logic [7:0] dbus;
    logic [7:0] e_inst;
    logic [2:0] e_cyc;
    logic [2:0] e_kind;
    logic [2:0] e_idx;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input logic rc, ic, sc, si, nm,
                              input logic [3:0] iq, input logic ds,
                              input logic [7:0] db, input logic [7:0] ei,
                              input logic [2:0] ec, input logic [2:0] ek,
                              input logic [2:0] ex, input logic ee);
    vec_t v;
    v.rcyc = rc; v.icyc = ic; v.scyc = sc; v.sinst = si; v.nmi = nm;
    v.irq = iq; v.dis = ds; v.dbus = db;
    v.e_inst = ei; v.e_cyc = ec; v.e_kind = ek; v.e_idx = ex; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(input logic rc, ic, sc, si, rd, nm,
                       input logic [3:0] iq, input logic ds, input logic [7:0] db);
    rcyc = rc; icyc = ic; scyc = sc; sinst = si; rdy = rd; nmi = nm;
    irq = iq; irq_dis = ds; dbus = db;
  endtask

  task automatic step(input logic rc, ic, sc, si, rd, nm,
                      input logic [3:0] iq, input logic ds, input logic [7:0] db);
    drive(rc, ic, sc, si, rd, nm, iq, ds, db);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ei, input logic [2:0] ec,
                       input logic [2:0] ek, input logic [2:0] ex, input logic ee);
    n_tests++;
    if (inst !== ei || cycle !== ec || {rst_o, nmi_o, irq_o} !== ek ||
        irq_idx !== ex || seq_err !== ee) begin
      n_fail++;
      $display("FAIL %s: got inst=%h cycle=%0d kind=%b idx=%0d err=%b, want inst=%h cycle=%0d kind=%b idx=%0d err=%b",
               nm, inst, cycle, {rst_o, nmi_o, irq_o}, irq_idx, seq_err,
               ei, ec, ek, ex, ee);
    end
  endtask

  vec_t vecs[$];

  initial begin
    // reset boot sequence
    vecs.push_back(mk(0,0,0,1,0,4'h0,0,8'hA9, 8'h00,3'd0,KR,3'd0,0));
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(0,1,0,0,0,4'h0,0,8'hA9, 8'h00,3'(i),KR,3'd0,0));
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,8'hA9, 8'hA9,3'd0,K0,3'd0,0));
    // NMI pulse mid-instruction
    vecs.push_back(mk(0,1,0,0,0,4'h0,0,8'hA9, 8'hA9,3'd1,K0,3'd0,0));
    vecs.push_back(mk(0,1,0,0,0,4'h0,0,8'hA9, 8'hA9,3'd2,K0,3'd0,0));
    vecs.push_back(mk(0,0,0,0,1,4'h0,0,8'hA9, 8'hA9,3'd2,K0,3'd0,0));
    vecs.push_back(mk(0,1,0,0,0,4'h0,0,8'hA9, 8'hA9,3'd3,K0,3'd0,0));
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,8'hA9, 8'h00,3'd0,KN,3'd0,0));
    vecs.push_back(mk(0,0,0,1,0,4'h0,0,8'hA9, 8'h00,3'd0,KN,3'd0,0));
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,8'h4C, 8'h4C,3'd0,K0,3'd0,0));
    // IRQ lowest index, then masked
    vecs.push_back(mk(1,0,0,0,0,4'hC,0,8'h4C, 8'h00,3'd0,KI,3'd2,0));
    vecs.push_back(mk(1,0,0,0,0,4'hC,1,8'hEA, 8'hEA,3'd0,K0,3'd0,0));
    // NMI and IRQ together: NMI wins, IRQ afterwards
    vecs.push_back(mk(0,0,1,0,1,4'h1,0,8'hEA, 8'hEA,3'd0,K0,3'd0,0));
    vecs.push_back(mk(1,0,0,0,1,4'h1,0,8'hEA, 8'h00,3'd0,KN,3'd0,0));
    vecs.push_back(mk(0,0,0,1,1,4'h1,0,8'hEA, 8'h00,3'd0,KN,3'd0,0));
    vecs.push_back(mk(1,0,0,0,0,4'h1,0,8'hEA, 8'h00,3'd0,KI,3'd0,0));
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,8'h20, 8'h20,3'd0,K0,3'd0,0));
    // strobe priority
    vecs.push_back(mk(0,1,1,0,0,4'h0,0,8'h20, 8'h20,3'd0,K0,3'd0,0));
    vecs.push_back(mk(1,1,0,0,0,4'h0,0,8'h60, 8'h60,3'd0,K0,3'd0,0));
    vecs.push_back(mk(0,1,0,0,0,4'h0,0,8'h60, 8'h60,3'd1,K0,3'd0,0));
    // late IRQ only sampled at boundary
    vecs.push_back(mk(0,1,0,0,0,4'h2,0,8'h60, 8'h60,3'd2,K0,3'd0,0));
    vecs.push_back(mk(1,0,0,0,0,4'h2,0,8'h60, 8'h00,3'd0,KI,3'd1,0));
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,8'h11, 8'h11,3'd0,K0,3'd0,0));

    clr = 1'b1;
    drive(0,0,0,0,1,0,4'h0,0,8'hA9);
    #12;
    check("reset", 8'h00, 3'd0, KR, 3'd0, 1'b0);
    clr = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].rcyc, vecs[i].icyc, vecs[i].scyc, vecs[i].sinst, 1'b1,
           vecs[i].nmi, vecs[i].irq, vecs[i].dis, vecs[i].dbus);
      check($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_cyc,
            vecs[i].e_kind, vecs[i].e_idx, vecs[i].e_err);
    end

    // stall: counter frozen, NMI edge still latched
    step(0,1,0,0,1,0,4'h0,0,8'h11);
    check("pre_stall", 8'h11, 3'd1, K0, 3'd0, 1'b0);
    step(0,1,0,0,0,1,4'h0,0,8'h11);
    check("stall1", 8'h11, 3'd1, K0, 3'd0, 1'b0);
    step(0,1,0,0,0,0,4'h0,0,8'h11);
    check("stall2", 8'h11, 3'd1, K0, 3'd0, 1'b0);
    step(1,1,0,0,0,0,4'h0,0,8'h11);
    check("stall3", 8'h11, 3'd1, K0, 3'd0, 1'b0);
    step(1,0,0,0,1,0,4'h0,0,8'h33);
    check("stall_nmi", 8'h00, 3'd0, KN, 3'd0, 1'b0);
    step(0,0,0,1,1,0,4'h0,0,8'h33);
    check("stall_sinst", 8'h00, 3'd0, KN, 3'd0, 1'b0);
    step(1,0,0,0,1,0,4'h0,0,8'h33);
    check("stall_fetch", 8'h33, 3'd0, K0, 3'd0, 1'b0);

    // overflow
    for (int i = 1; i <= 7; i++) begin
      step(0,1,0,0,1,0,4'h0,0,8'h33);
      check($sformatf("ovf_c%0d", i), 8'h33, 3'(i), K0, 3'd0, 1'b0);
    end
    step(0,1,0,0,1,0,4'h0,0,8'h33);
    check("ovf_wrap", 8'h33, 3'd0, K0, 3'd0, 1'b1);
    step(1,0,0,0,1,0,4'h0,0,8'h44);
    check("ovf_sticky", 8'h44, 3'd0, K0, 3'd0, 1'b1);
    for (int i = 1; i <= 4; i++) step(0,1,0,0,1,0,4'h0,0,8'h44);
    check("ovf_c4", 8'h44, 3'd4, K0, 3'd0, 1'b1);

    // NMI pending, then async clr mid-cycle drops it
    step(0,0,0,0,1,1,4'h0,0,8'h44);
    check("pre_clr", 8'h44, 3'd4, K0, 3'd0, 1'b1);
    #2;
    clr = 1'b1;
    nmi = 1'b0;
    #1;
    check("async_clr", 8'h00, 3'd0, KR, 3'd0, 1'b0);
    #3;
    clr = 1'b0;
    step(0,0,0,1,1,0,4'h0,0,8'h55);
    check("clr_sinst", 8'h00, 3'd0, KR, 3'd0, 1'b0);
    step(1,0,0,0,1,0,4'h0,0,8'h55);
    check("clr_nmi_dropped", 8'h55, 3'd0, K0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tstate_sequencer.md
Name: tstate_sequencer

Overview:
- Sequential front end for the instruction decoder.
- Owns the instruction register and the T-state (cycle) counter, and arbitrates reset, NMI and multiple maskable IRQ lines.
- Injects the interrupt opcode at instruction boundaries.
- Feeds `inst`, `cycle` and one-hot interrupt-kind flags to the decoder, and consumes the decoder's cycle-control strobes (`icyc`, `rcyc`, `scyc`, `sinst`).

Parameters:
- CYC_W, 3, width of the cycle counter; maximum T-state = 2**CYC_W-1.
- OPC_W, 8, opcode width.
- INT_OPC, 8'h00, opcode injected for reset, NMI and IRQ sequences.
- NUM_IRQ, 1, number of maskable IRQ lines (1..8).
- IDX_W, 3, width of `irq_idx`; must be ≥ clog2(NUM_IRQ), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- rdy  in  1  memory ready; low freezes sequencing.
- dbus  in  OPC_W  data bus, carries the opcode on fetch.
- icyc  in  1  decoder: advance to the next T-state.
- rcyc  in  1  decoder: instruction complete, fetch the next opcode.
- scyc  in  1  decoder: hold the current T-state for one cycle.
- sinst  in  1  decoder: interrupt sequence accepted.
- irq  in  NUM_IRQ  maskable interrupt requests, level-sensitive.
- irq_dis  in  1  status I flag; masks all irq.
- nmi  in  1  non-maskable interrupt, rising-edge-sensitive.
- inst  out  OPC_W  instruction register to the decoder.
- cycle  out  CYC_W  current T-state.
- rst_o  out  1  current sequence is reset.
- nmi_o  out  1  current sequence is NMI.
- irq_o  out  1  current sequence is IRQ.
- irq_idx  out  IDX_W  index of the IRQ line being serviced.
- seq_err  out  1  sticky: cycle counter overflow.

Behaviour:
- **Async reset (clr=1):** `inst`=INT_OPC, `cycle`=0, `rst_pend`=1, `nmi_pend`=0, `nmi_q`=0, `rst_o`=1, `nmi_o`=0, `irq_o`=0, `irq_idx`=0, `seq_err`=0. All state is registered.
- **Initial interrupt kind:** after clr falls, the first sequence executed is the reset sequence. The kind flags are valid from cycle 0.
- **Stall:** `rdy`=0 freezes `inst`, `cycle`, the kind flags and `rst_pend`. NMI edge detection (`nmi_q` <= `nmi`, `nmi_pend` set) continues.
- **Strobe priority (rdy=1):** `rcyc` > `scyc` > `icyc`. No strobe means hold.
- **icyc:** `cycle` <= `cycle`+1.
  - At `cycle`=max: `cycle` wraps to 0, `seq_err` <= 1 (sticky until clr), `inst` is unchanged.
- **scyc:** `cycle` held for that clock.
- **rcyc (instruction boundary):** `cycle` <= 0, and `inst`/kind flags load per arbitration:
  1. `rst_pend` → INT_OPC, `rst_o`=1.
  2. `nmi_pend` → INT_OPC, `nmi_o`=1.
  3. any (`irq` & ~`irq_dis`) → INT_OPC, `irq_o`=1, `irq_idx` = lowest set index.
  4. otherwise → `inst` <= `dbus`, all kind flags 0.
- **Kind flags:** exactly zero or one is set. They stay stable for the whole sequence, until the next `rcyc`.
- **NMI edge detect:** `nmi_q` registers `nmi`. `nmi` & ~`nmi_q` sets `nmi_pend`.
- **sinst:** clears the pending source of the current kind.
  - `rst_o` → `rst_pend`<=0.
  - `nmi_o` → `nmi_pend`<=0, unless a new NMI edge arrives in the same clock; set wins.
  - `irq` is level-sensitive, so there is no IRQ latch; the source deasserts its own line.
- **Late IRQ:** an IRQ arriving mid-instruction is sampled only at the next `rcyc`.
- **Mask timing:** an `irq_dis` change takes effect at the next `rcyc` (combinational sample).
- **Reset mid-operation:** clr at any cycle restarts the reset sequence immediately. In-progress NMI/IRQ state is dropped.

Decomposition:
- **Shared package:** INT_OPC, the kind encoding (KIND_NONE/RST/NMI/IRQ), and a function returning the lowest set index of a NUM_IRQ vector. The decoder also imports the package.
- **Sub-module:** `int_arbiter` — combinational priority arbiter plus `nmi_pend`/`rst_pend` latches and NMI edge detect. Outputs the chosen kind and index to the sequencer core.

Test Plan:
- Release clr, dbus=8'hA9, issue sinst then icyc x6, rcyc → `inst` 8'h00 with `rst_o`=1 through `cycle` 0..6; after rcyc `inst`=8'hA9, `cycle`=0, all flags 0.
- Pulse nmi one clock mid-instruction (cycle 2), then rcyc → `nmi_o`=1, `inst`=8'h00; sinst clears the pend; next rcyc fetches `dbus`.
- NUM_IRQ=4, irq=4'b1100, irq_dis=0, rcyc → `irq_o`=1, `irq_idx`=2. Repeat with irq_dis=1 → `inst`=`dbus`, `irq_o`=0.
- nmi edge and irq=4'b0001 arrive together, rcyc → `nmi_o` wins. After sinst and rcyc, with irq still high → `irq_o`=1, `irq_idx`=0.
- rdy=0 for 3 clocks with icyc=1 → `cycle` unchanged. An nmi edge during the stall is still latched (`nmi_o`=1 at the next rcyc).
- CYC_W=3, 8 consecutive icyc from cycle 0 → `cycle` goes 7→0, `seq_err`=1 and stays 1 until clr. Also assert clr at cycle 4 → async reset values are seen immediately.
